// File: rtl/rat_commit_ctrl_pkg.sv
// Shared sizing, FSM state type and ID helpers for the RAT commit controller.
package rat_commit_ctrl_pkg;

   localparam int COMMIT_WIDTH     = 2;
   localparam int PHY_REG_NUM      = 64;
   localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);
   localparam int RETIRE_CNT_W     = $clog2(COMMIT_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      DONE
   } commit_rat_state_t;

   typedef logic [PHY_REG_ID_WIDTH-1:0] phy_id_t;

   // RAT commit/release ports are PHY_REG_NUM wide with the ID in the low bits.
   function automatic logic [PHY_REG_NUM-1:0] widen_id(input phy_id_t id);
      return {{(PHY_REG_NUM - PHY_REG_ID_WIDTH){1'b0}}, id};
   endfunction

endpackage

// File: rtl/rat_commit_ctrl_if.sv
// ROB-to-commit and commit-to-RAT signal bundle; slave is the controller side.
interface rat_commit_ctrl_if;
   import rat_commit_ctrl_pkg::*;

   logic [COMMIT_WIDTH-1:0]     rob_commit_valid;
   logic [COMMIT_WIDTH-1:0]     rob_commit_has_dest;
   phy_id_t                     rob_commit_new_phy_id [COMMIT_WIDTH];
   phy_id_t                     rob_commit_old_phy_id [COMMIT_WIDTH];
   logic                        commit_rob_ready;
   logic                        rob_flush;
   logic                        rob_walk_valid;
   logic                        rob_walk_has_dest;
   logic                        rob_walk_last;
   phy_id_t                     rob_walk_new_phy_id;
   phy_id_t                     rob_walk_old_phy_id;
   logic                        commit_rob_walk_ready;
   logic [PHY_REG_NUM-1:0]      commit_rat_commit_phy_id [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0]     commit_rat_commit_phy_id_valid;
   logic                        commit_rat_commit_map;
   logic [PHY_REG_NUM-1:0]      commit_rat_release_phy_id [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0]     commit_rat_release_phy_id_valid;
   logic                        commit_rat_release_map;
   phy_id_t                     commit_rat_restore_new_phy_id;
   phy_id_t                     commit_rat_restore_old_phy_id;
   logic                        commit_rat_restore_map;
   logic                        commit_rename_walk_done;
   logic [63:0]                 commit_csr_instret;

   modport master (
      output rob_commit_valid, rob_commit_has_dest, rob_commit_new_phy_id, rob_commit_old_phy_id,
      output rob_flush, rob_walk_valid, rob_walk_has_dest, rob_walk_last,
      output rob_walk_new_phy_id, rob_walk_old_phy_id,
      input  commit_rob_ready, commit_rob_walk_ready,
      input  commit_rat_commit_phy_id, commit_rat_commit_phy_id_valid, commit_rat_commit_map,
      input  commit_rat_release_phy_id, commit_rat_release_phy_id_valid, commit_rat_release_map,
      input  commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id, commit_rat_restore_map,
      input  commit_rename_walk_done, commit_csr_instret
   );

   modport slave (
      input  rob_commit_valid, rob_commit_has_dest, rob_commit_new_phy_id, rob_commit_old_phy_id,
      input  rob_flush, rob_walk_valid, rob_walk_has_dest, rob_walk_last,
      input  rob_walk_new_phy_id, rob_walk_old_phy_id,
      output commit_rob_ready, commit_rob_walk_ready,
      output commit_rat_commit_phy_id, commit_rat_commit_phy_id_valid, commit_rat_commit_map,
      output commit_rat_release_phy_id, commit_rat_release_phy_id_valid, commit_rat_release_map,
      output commit_rat_restore_new_phy_id, commit_rat_restore_old_phy_id, commit_rat_restore_map,
      output commit_rename_walk_done, commit_csr_instret
   );

endinterface

// File: rtl/rat_commit_ctrl_popcount.sv
// Population count of a small bit vector; sizes the retired-instruction increment.
module popcount #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0]               bits,
   output logic [$clog2(WIDTH+1)-1:0]     count
);
   localparam int CW = $clog2(WIDTH + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/rat_commit_ctrl.sv
// Commit-side RAT driver: registered commit/release updates, flush walk restore,
// and the retired-instruction counter.
module rat_commit_ctrl
   import rat_commit_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   rat_commit_ctrl_if.slave bus
);

   commit_rat_state_t          state_q, state_d;
   logic                       accept;
   logic                       walk_accept;
   logic [COMMIT_WIDTH-1:0]    commit_vld;
   logic [COMMIT_WIDTH-1:0]    release_vld;
   logic [COMMIT_WIDTH-1:0]    retire_vld;
   logic [RETIRE_CNT_W-1:0]    retire_cnt;

   logic                       map_vld_p1;
   logic                       restore_vld_p1;
   phy_id_t                    restore_new_p1;
   phy_id_t                    restore_old_p1;
   logic                       walk_done_p1;
   logic [63:0]                instret_p1;

   // Holding rst in the ready term keeps every output low while reset is asserted.
   assign accept      = (state_q == IDLE) && !bus.rob_flush && !rst;
   assign walk_accept = (state_q == WALK) && bus.rob_walk_valid;
   assign retire_vld  = accept ? bus.rob_commit_valid : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.rob_flush) state_d = WALK;
         WALK:    if (walk_accept && bus.rob_walk_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   popcount #(.WIDTH(COMMIT_WIDTH)) u_popcount (
      .bits  (retire_vld),
      .count (retire_cnt)
   );

   for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_lane
      logic    commit_vld_p1;
      logic    release_vld_p1;
      phy_id_t commit_id_p1;
      phy_id_t release_id_p1;

      assign commit_vld[k] = accept && bus.rob_commit_valid[k] && bus.rob_commit_has_dest[k];
      // Physical register 0 is never handed back to the free list.
      assign release_vld[k] = commit_vld[k] && (bus.rob_commit_old_phy_id[k] != '0);

      // ---- stage p1: per-lane RAT update registers ----
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            commit_vld_p1  <= 1'b0;
            release_vld_p1 <= 1'b0;
            commit_id_p1   <= '0;
            release_id_p1  <= '0;
         end else begin
            commit_vld_p1  <= commit_vld[k];
            release_vld_p1 <= release_vld[k];
            commit_id_p1   <= commit_vld[k]  ? bus.rob_commit_new_phy_id[k] : '0;
            release_id_p1  <= release_vld[k] ? bus.rob_commit_old_phy_id[k] : '0;
         end
      end

      assign bus.commit_rat_commit_phy_id[k]        = widen_id(commit_id_p1);
      assign bus.commit_rat_commit_phy_id_valid[k]  = commit_vld_p1;
      assign bus.commit_rat_release_phy_id[k]       = widen_id(release_id_p1);
      assign bus.commit_rat_release_phy_id_valid[k] = release_vld_p1;
   end

   // ---- stage p1: map strobes, walk restore, walk done, instret ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         map_vld_p1     <= 1'b0;
         restore_vld_p1 <= 1'b0;
         restore_new_p1 <= '0;
         restore_old_p1 <= '0;
         walk_done_p1   <= 1'b0;
         instret_p1     <= '0;
      end else begin
         map_vld_p1     <= |commit_vld;
         restore_vld_p1 <= walk_accept && bus.rob_walk_has_dest;
         restore_new_p1 <= (walk_accept && bus.rob_walk_has_dest) ? bus.rob_walk_new_phy_id : '0;
         restore_old_p1 <= (walk_accept && bus.rob_walk_has_dest) ? bus.rob_walk_old_phy_id : '0;
         walk_done_p1   <= walk_accept && bus.rob_walk_last;
         instret_p1     <= instret_p1 + 64'(retire_cnt);
      end
   end

   assign bus.commit_rob_ready              = accept;
   assign bus.commit_rob_walk_ready         = (state_q == WALK);
   assign bus.commit_rat_commit_map         = map_vld_p1;
   assign bus.commit_rat_release_map        = map_vld_p1;
   assign bus.commit_rat_restore_map        = restore_vld_p1;
   assign bus.commit_rat_restore_new_phy_id = restore_new_p1;
   assign bus.commit_rat_restore_old_phy_id = restore_old_p1;
   assign bus.commit_rename_walk_done       = walk_done_p1;
   assign bus.commit_csr_instret            = instret_p1;

endmodule

// File: tb/tb_rat_commit_ctrl.sv
// Directed bench for rat_commit_ctrl with a one-cycle-latency expectation scoreboard.
module tb_rat_commit_ctrl;
   import rat_commit_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rat_commit_ctrl_if bus ();
   rat_commit_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [63:0] cid0, cid1, rid0, rid1;
      logic [1:0]  cvld, rvld;
      logic        map, rs_map, done;
      logic [5:0]  rs_new, rs_old;
      logic [63:0] instret;
   } exp_t;

   exp_t              sb [$];
   int                checks = 0;
   int                errors = 0;
   commit_rat_state_t m_state;
   logic [63:0]       m_instret;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.rob_commit_valid    = '0;
      bus.rob_commit_has_dest = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         bus.rob_commit_new_phy_id[i] = '0;
         bus.rob_commit_old_phy_id[i] = '0;
      end
      bus.rob_flush           = 1'b0;
      bus.rob_walk_valid      = 1'b0;
      bus.rob_walk_has_dest   = 1'b0;
      bus.rob_walk_last       = 1'b0;
      bus.rob_walk_new_phy_id = '0;
      bus.rob_walk_old_phy_id = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rob_ready"},  64'(bus.commit_rob_ready), 64'd0);
      chk({tag, "_walk_ready"}, 64'(bus.commit_rob_walk_ready), 64'd0);
      chk({tag, "_cid0"},       bus.commit_rat_commit_phy_id[0], 64'd0);
      chk({tag, "_cid1"},       bus.commit_rat_commit_phy_id[1], 64'd0);
      chk({tag, "_cvld"},       64'(bus.commit_rat_commit_phy_id_valid), 64'd0);
      chk({tag, "_rvld"},       64'(bus.commit_rat_release_phy_id_valid), 64'd0);
      chk({tag, "_maps"},       64'({bus.commit_rat_commit_map, bus.commit_rat_release_map}), 64'd0);
      chk({tag, "_restore"},    64'({bus.commit_rat_restore_map, bus.commit_rat_restore_new_phy_id,
                                      bus.commit_rat_restore_old_phy_id}), 64'd0);
      chk({tag, "_done"},       64'(bus.commit_rename_walk_done), 64'd0);
      chk({tag, "_instret"},    bus.commit_csr_instret, 64'd0);
   endtask

   task automatic compare(input exp_t e);
      chk("commit_id0",    bus.commit_rat_commit_phy_id[0], e.cid0);
      chk("commit_id1",    bus.commit_rat_commit_phy_id[1], e.cid1);
      chk("commit_vld",    64'(bus.commit_rat_commit_phy_id_valid), 64'(e.cvld));
      chk("release_id0",   bus.commit_rat_release_phy_id[0], e.rid0);
      chk("release_id1",   bus.commit_rat_release_phy_id[1], e.rid1);
      chk("release_vld",   64'(bus.commit_rat_release_phy_id_valid), 64'(e.rvld));
      chk("commit_map",    64'(bus.commit_rat_commit_map), 64'(e.map));
      chk("release_map",   64'(bus.commit_rat_release_map), 64'(e.map));
      chk("restore_map",   64'(bus.commit_rat_restore_map), 64'(e.rs_map));
      chk("restore_new",   64'(bus.commit_rat_restore_new_phy_id), 64'(e.rs_new));
      chk("restore_old",   64'(bus.commit_rat_restore_old_phy_id), 64'(e.rs_old));
      chk("walk_done",     64'(bus.commit_rename_walk_done), 64'(e.done));
      chk("instret",       bus.commit_csr_instret, e.instret);
   endtask

   // One clock of stimulus: drive at negedge, predict, then compare after the edge.
   task automatic cycle(input logic [1:0] cv, input logic [1:0] cd,
                        input logic [5:0] n0, input logic [5:0] o0,
                        input logic [5:0] n1, input logic [5:0] o1,
                        input logic fl, input logic wv, input logic wd, input logic wl,
                        input logic [5:0] wn, input logic [5:0] wo);
      exp_t e;
      logic acc, wacc;
      logic [1:0] lv;
      @(negedge clk);
      bus.rob_commit_valid         = cv;
      bus.rob_commit_has_dest      = cd;
      bus.rob_commit_new_phy_id[0] = n0;
      bus.rob_commit_old_phy_id[0] = o0;
      bus.rob_commit_new_phy_id[1] = n1;
      bus.rob_commit_old_phy_id[1] = o1;
      bus.rob_flush                = fl;
      bus.rob_walk_valid           = wv;
      bus.rob_walk_has_dest        = wd;
      bus.rob_walk_last            = wl;
      bus.rob_walk_new_phy_id      = wn;
      bus.rob_walk_old_phy_id      = wo;
      #1;
      acc  = (m_state == IDLE) && !fl;
      wacc = (m_state == WALK) && wv;
      chk("rob_ready",  64'(bus.commit_rob_ready), 64'(acc));
      chk("walk_ready", 64'(bus.commit_rob_walk_ready), 64'(m_state == WALK));
      lv      = acc ? (cv & cd) : 2'b00;
      e.cvld  = lv;
      e.cid0  = lv[0] ? 64'(n0) : 64'd0;
      e.cid1  = lv[1] ? 64'(n1) : 64'd0;
      e.rvld  = {lv[1] && (o1 != 6'd0), lv[0] && (o0 != 6'd0)};
      e.rid0  = e.rvld[0] ? 64'(o0) : 64'd0;
      e.rid1  = e.rvld[1] ? 64'(o1) : 64'd0;
      e.map   = |lv;
      if (acc) m_instret = m_instret + 64'(cv[0]) + 64'(cv[1]);
      e.instret = m_instret;
      e.rs_map  = wacc && wd;
      e.rs_new  = e.rs_map ? wn : 6'd0;
      e.rs_old  = e.rs_map ? wo : 6'd0;
      e.done    = wacc && wl;
      case (m_state)
         IDLE:    if (fl) m_state = WALK;
         WALK:    if (wacc && wl) m_state = DONE;
         default: m_state = IDLE;
      endcase
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare(sb.pop_front());
   endtask

   task automatic idle_cycle();
      cycle(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      logic [1:0] rcv;
      rst = 1'b1;
      idle_inputs();
      m_state   = IDLE;
      m_instret = '0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      idle_cycle();

      // Two-lane commit; lane 1 hid p0 so it releases nothing.
      cycle(2'b11, 2'b11, 40, 5, 41, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      idle_cycle();
      // Valid lane without a destination counts toward instret only.
      cycle(2'b01, 2'b00, 9, 9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      cycle(2'b01, 2'b01, 17, 33, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

      // Flush with a live bundle, then a gapped walk with a no-dest entry.
      cycle(2'b11, 2'b11, 50, 6, 51, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      cycle(2'b11, 2'b11, 50, 6, 51, 8, 1'b0, 1'b1, 1'b1, 1'b0, 45, 12);
      cycle(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 63, 63);
      cycle(2'b11, 2'b11, 50, 6, 51, 8, 1'b0, 1'b1, 1'b0, 1'b0, 30, 31);
      cycle(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 44, 7);
      cycle(2'b11, 2'b11, 50, 6, 51, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      idle_cycle();

      // Empty walk: a single no-dest entry marked last.
      cycle(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      cycle(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 22, 23);
      idle_cycle();
      idle_cycle();

      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 2))
            0:       rcv = 2'b00;
            1:       rcv = 2'b01;
            default: rcv = 2'b11;
         endcase
         cycle(rcv, 2'($urandom), 6'($urandom), 6'($urandom_range(0, 3)),
               6'($urandom), 6'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      end

      // Reset asserted mid-cycle while a restore and walk-done are pending.
      cycle(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      bus.rob_walk_valid      = 1'b1;
      bus.rob_walk_has_dest   = 1'b1;
      bus.rob_walk_last       = 1'b1;
      bus.rob_walk_new_phy_id = 6'd20;
      bus.rob_walk_old_phy_id = 6'd3;
      @(posedge clk);
      #1;
      idle_inputs();
      chk("midwalk_restore_map", 64'(bus.commit_rat_restore_map), 64'd1);
      chk("midwalk_done_pre",    64'(bus.commit_rename_walk_done), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midwalk_reset");
      @(negedge clk);
      rst       = 1'b0;
      m_state   = IDLE;
      m_instret = '0;
      idle_cycle();

      // instret wrap from all-ones.
      @(negedge clk);
      force dut.instret_p1 = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_p1;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle(2'b01, 2'b01, 30, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      cycle(2'b01, 2'b01, 31, 30, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      idle_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
